wb_spi_bridge: RTL and testbench

WB_SPI_BRIDGE -- requirements
Module: wb_spi_bridge

---
 rtl/wb_spi_bridge.sv | 131 +++++++++++++
 tb/tb_wb_spi_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_bridge.sv
// wb_spi_bridge: Wishbone classic slave bridging CTRL/DATA/STATUS words onto a strobed SPI command port.
//   clk, rst          : clock, synchronous active-high reset
//   wb_*_i / wb_*_o   : Wishbone slave (2-bit word address, 32-bit data, sel ignored)
//   spi_din/cmd/wr/rd : registered downstream payload and one-cycle strobes
//   spi_dout/spi_ack  : downstream read data (bit8 = no data) and ack one cycle after a strobe
module wb_spi_bridge #(
  parameter int MAX_RETRY = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [10:0] spi_din,
  output logic        spi_cmd,
  output logic        spi_wr,
  output logic        spi_rd,
  input  logic [8:0]  spi_dout,
  input  logic        spi_ack
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [7:0] MR = 8'(MAX_RETRY);
  state_t state, state_n;
  logic we, we_n, err_flag, err_flag_n, ack_n, err_n, cmd_n, wr_n, rd_n, clr, req, unused;
  logic [1:0] adr, adr_n;
  logic [10:0] din_n, shadow, shadow_n;
  logic [7:0] attempts, attempts_n, err_cnt, err_cnt_n;
  logic [31:0] dat_n, status;
  assign req = wb_cyc_i & wb_stb_i;
  assign status = {16'b0, err_cnt, 7'b0, err_flag};
  assign unused = ^{wb_sel_i, wb_dat_i[31:11]};
  always_comb begin
    state_n = state;
    we_n = we;
    adr_n = adr;
    din_n = spi_din;
    attempts_n = attempts;
    shadow_n = shadow;
    dat_n = wb_dat_o;
    ack_n = 1'b0;
    err_n = 1'b0;
    cmd_n = 1'b0;
    wr_n = 1'b0;
    rd_n = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE: begin
        attempts_n = '0;
        if (req) begin
          we_n = wb_we_i;
          adr_n = wb_adr_i;
          din_n = wb_dat_i[10:0];
          cmd_n = wb_adr_i == 2'd0 && wb_we_i;
          wr_n = wb_adr_i == 2'd1 && wb_we_i;
          rd_n = wb_adr_i == 2'd1 && !wb_we_i;
          if (cmd_n | wr_n | rd_n) begin
            state_n = ISSUE;
            attempts_n = 8'd1;
          end else begin
            // CTRL read, STATUS and reserved are answered locally without a downstream strobe
            state_n = RESP;
            ack_n = wb_adr_i != 2'd3;
            err_n = wb_adr_i == 2'd3;
            clr = wb_we_i && wb_adr_i == 2'd2 && wb_dat_i[0];
            if (!wb_we_i) dat_n = wb_adr_i == 2'd0 ? {21'b0, shadow} : wb_adr_i == 2'd2 ? status : '0;
          end
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // only CTRL writes reach WAIT with adr 0; the shadow update stands even if the master aborts
        if (spi_ack && adr == 2'd0) shadow_n = spi_din;
        if (!wb_cyc_i) state_n = IDLE;
        else if (spi_ack) begin
          state_n = RESP;
          ack_n = 1'b1;
          if (!we) dat_n = {23'b0, spi_dout};
        end else if (we && adr == 2'd1 && attempts < MR) begin
          state_n = ISSUE;
          attempts_n = attempts + 8'd1;
          wr_n = 1'b1;
        end else begin
          state_n = RESP;
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    err_flag_n = err_n | (err_flag & ~clr);
    err_cnt_n = err_n ? (clr ? 8'd1 : err_cnt + {7'b0, err_cnt != 8'hFF}) : clr ? '0 : err_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we <= 1'b0;
      adr <= '0;
      spi_din <= '0;
      attempts <= '0;
      shadow <= '0;
      err_flag <= 1'b0;
      err_cnt <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      spi_cmd <= 1'b0;
      spi_wr <= 1'b0;
      spi_rd <= 1'b0;
    end else begin
      state <= state_n;
      we <= we_n;
      adr <= adr_n;
      spi_din <= din_n;
      attempts <= attempts_n;
      shadow <= shadow_n;
      err_flag <= err_flag_n;
      err_cnt <= err_cnt_n;
      wb_dat_o <= dat_n;
      wb_ack_o <= ack_n;
      wb_err_o <= err_n;
      spi_cmd <= cmd_n;
      spi_wr <= wr_n;
      spi_rd <= rd_n;
    end
  end
endmodule

// File: tb/tb_wb_spi_bridge.sv
// tb_wb_spi_bridge: directed and randomized checks of wb_spi_bridge against a transaction-level model.
module tb_wb_spi_bridge;
  localparam int MR = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0] sel = '0;
  logic [31:0] wb_dat_o;
  logic wb_ack_o, wb_err_o, spi_cmd, spi_wr, spi_rd, spi_ack;
  logic [10:0] spi_din;
  logic [8:0] spi_dout = '0;
  logic model_clr = 1'b1;
  int withhold = 0, nstb = 0;
  int total = 0, bad = 0;
  logic [10:0] m_shadow = '0;
  logic m_flag = 1'b0;
  logic [7:0] m_cnt = '0;
  logic [31:0] m_dat = '0;

  wb_spi_bridge #(.MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .spi_din(spi_din), .spi_cmd(spi_cmd), .spi_wr(spi_wr), .spi_rd(spi_rd),
    .spi_dout(spi_dout), .spi_ack(spi_ack)
  );

  always #5 clk = ~clk;

  // downstream device: withholds ack for the first `withhold` strobes of a transfer, then acks
  always @(posedge clk) begin
    if (model_clr) nstb <= 0;
    else if (spi_cmd | spi_wr | spi_rd) nstb <= nstb + 1;
    spi_ack <= !model_clr && (spi_cmd | spi_wr | spi_rd) && nstb >= withhold;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {16'b0, m_cnt, 7'b0, m_flag};
  endfunction

  task automatic m_error();
    m_flag = 1'b1;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic start(input logic w, input logic [1:0] a, input logic [31:0] d, input int wh, input logic [8:0] dout);
    @(negedge clk);
    model_clr = 1'b1;
    withhold = wh;
    spi_dout = dout;
    @(negedge clk);
    model_clr = 1'b0;
    cyc = 1'b1;
    stb = 1'b1;
    we = w;
    adr = a;
    dat = d;
    sel = 4'($urandom);
  endtask

  task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d, input int wh, input logic [8:0] dout);
    int lat, ncmd, nwr, nrd, k, ccmd, cwr, crd, first, last;
    logic exp_err, seen, got_ack, got_err;
    lat = 1; ncmd = 0; nwr = 0; nrd = 0; exp_err = 1'b0;
    if (a == 2'd0 && w) begin
      ncmd = 1; lat = 3; exp_err = wh > 0;
      if (!exp_err) m_shadow = d[10:0];
    end else if (a == 2'd1 && w) begin
      if (wh < MR) begin nwr = wh + 1; lat = 3 + 2 * wh; end
      else begin nwr = MR; lat = 3 + 2 * (MR - 1); exp_err = 1'b1; end
    end else if (a == 2'd1) begin
      nrd = 1; lat = 3; exp_err = wh > 0;
      if (!exp_err) m_dat = {23'b0, dout};
    end else if (a == 2'd3) begin
      exp_err = 1'b1;
      if (!w) m_dat = '0;
    end else if (!w) m_dat = a == 2'd0 ? {21'b0, m_shadow} : m_status();
    else if (d[0]) begin m_flag = 1'b0; m_cnt = '0; end
    if (exp_err) m_error();
    start(w, a, d, wh, dout);
    k = 0; seen = 1'b0; ccmd = 0; cwr = 0; crd = 0; first = -1; last = -1;
    while (!seen && k < 60) begin
      @(posedge clk); #1;
      k++;
      ccmd += int'(spi_cmd);
      cwr += int'(spi_wr);
      crd += int'(spi_rd);
      if (spi_cmd | spi_wr | spi_rd) begin
        if (first < 0) first = k;
        last = k;
      end
      seen = wb_ack_o | wb_err_o;
    end
    got_ack = wb_ack_o;
    got_err = wb_err_o;
    cyc = 1'b0;
    stb = 1'b0;
    chk("latency", 32'(k), 32'(lat));
    chk("resp_kind", 32'({got_ack, got_err}), exp_err ? 32'd1 : 32'd2);
    chk("strobes", {8'd0, 8'(ccmd), 8'(cwr), 8'(crd)}, {8'd0, 8'(ncmd), 8'(nwr), 8'(nrd)});
    if (ncmd + nwr + nrd > 0) chk("strobe_timing", {16'(first), 16'(last)}, {16'd1, 16'(1 + 2 * (ncmd + nwr + nrd - 1))});
    chk("spi_din", 32'(spi_din), 32'(d[10:0]));
    if (!(a == 2'd1 && !w && exp_err)) chk("wb_dat_o", wb_dat_o, m_dat);
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'({wb_ack_o, wb_err_o}), 32'd0);
  endtask

  task automatic abort_xfer(input logic w, input logic [1:0] a, input logic [31:0] d, input int wh, input int drop);
    logic got;
    if (a == 2'd0 && w && wh == 0 && drop >= 2) m_shadow = d[10:0];
    start(w, a, d, wh, 9'h0);
    got = 1'b0;
    for (int i = 0; i < drop; i++) begin
      @(posedge clk); #1;
      got |= wb_ack_o | wb_err_o;
    end
    cyc = 1'b0;
    stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      got |= wb_ack_o | wb_err_o;
    end
    chk("abort_no_resp", 32'(got), 32'd0);
  endtask

  initial begin
    logic w;
    logic [1:0] a;
    int wh;
    logic got;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, wb_ack_o, wb_err_o, spi_cmd, spi_wr, spi_rd, spi_ack}, 32'd0);
    chk("reset_din", 32'(spi_din), 32'd0);
    chk("reset_dat_o", wb_dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(1'b1, 2'd0, 32'h0000_0419, 0, 9'h0);
    xfer(1'b0, 2'd0, 32'h0, 0, 9'h0);
    chk("ctrl_readback", wb_dat_o, 32'h419);
    xfer(1'b1, 2'd1, 32'h0000_02A5, 0, 9'h0);
    xfer(1'b1, 2'd1, 32'hFFFF_F123, 3, 9'h0);
    xfer(1'b1, 2'd1, 32'h0000_0077, 255, 9'h0);
    xfer(1'b0, 2'd2, 32'h0, 0, 9'h0);
    chk("status_after_err", wb_dat_o, 32'h0000_0101);
    xfer(1'b1, 2'd2, 32'h1, 0, 9'h0);
    xfer(1'b0, 2'd2, 32'h0, 0, 9'h0);
    chk("status_cleared", wb_dat_o, 32'h0);
    xfer(1'b0, 2'd1, 32'h0, 0, 9'h100);
    xfer(1'b0, 2'd1, 32'h0, 0, 9'h05C);
    xfer(1'b1, 2'd0, 32'h0000_0155, 1, 9'h0);
    xfer(1'b0, 2'd1, 32'h0, 1, 9'h0AA);
    abort_xfer(1'b1, 2'd1, 32'h0000_0222, 255, 4);
    abort_xfer(1'b1, 2'd0, 32'h0000_03C7, 0, 2);
    xfer(1'b0, 2'd0, 32'h0, 0, 9'h0);
    xfer(1'b0, 2'd2, 32'h0, 0, 9'h0);
    xfer(1'b0, 2'd3, 32'h0, 0, 9'h0);
    xfer(1'b1, 2'd3, 32'h0000_0456, 0, 9'h0);
    for (int i = 0; i < 60; i++) begin
      a = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      if (w && a == 2'd1) wh = $urandom_range(0, 7);
      else if (w && a == 2'd0) wh = $urandom_range(0, 1);
      else wh = 0;
      xfer(w, a, $urandom, wh, 9'($urandom));
    end
    xfer(1'b0, 2'd2, 32'h0, 0, 9'h0);
    xfer(1'b1, 2'd2, 32'h1, 0, 9'h0);
    for (int i = 0; i < 260; i++) xfer(1'b1, 2'd3, $urandom, 0, 9'h0);
    xfer(1'b0, 2'd2, 32'h0, 0, 9'h0);
    chk("err_cnt_saturates", wb_dat_o, 32'h0000_FF01);
    start(1'b1, 2'd1, 32'h0000_0333, 255, 9'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 1'b0;
    stb = 1'b0;
    m_shadow = '0; m_flag = 1'b0; m_cnt = '0; m_dat = '0;
    got = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got |= wb_ack_o | wb_err_o | spi_cmd | spi_wr | spi_rd;
      @(posedge clk); #1;
    end
    chk("reset_mid_transfer_quiet", 32'(got), 32'd0);
    chk("reset_mid_dat_o", wb_dat_o, 32'd0);
    xfer(1'b0, 2'd2, 32'h0, 0, 9'h0);
    xfer(1'b0, 2'd0, 32'h0, 0, 9'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
